// File: rtl/atm_session_ctrl.sv
// ATM session engine: account/PIN/balance table with one authenticated session,
// valid/ready request and response handshakes, PIN lockout and idle-timeout logout.
module atm_session_ctrl #(
  parameter int unsigned NUM_ACCTS   = 10,
  parameter int unsigned ACC_W       = 12,
  parameter int unsigned PIN_W       = 4,
  parameter int unsigned BAL_W       = 16,
  parameter int unsigned AMT_W       = 11,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 100,
  parameter int unsigned INIT_BAL    = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [ACC_W-1:0] cfg_acc,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [ACC_W-1:0] req_acc,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [ACC_W-1:0] req_dest,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             session_active,
  output logic             timeout_pulse
);
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] OP_LOGIN    = 3'd0;
  localparam logic [2:0] OP_LOGOUT   = 3'd1;
  localparam logic [2:0] OP_BALANCE  = 3'd2;
  localparam logic [2:0] OP_WITHDRAW = 3'd3;
  localparam logic [2:0] OP_DEPOSIT  = 3'd4;
  localparam logic [2:0] OP_XFER     = 3'd5;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_CRED = 3'd1;
  localparam logic [2:0] ST_LOCKED   = 3'd2;
  localparam logic [2:0] ST_NSF      = 3'd3;
  localparam logic [2:0] ST_OVERFLOW = 3'd4;
  localparam logic [2:0] ST_NO_DEST  = 3'd5;
  localparam logic [2:0] ST_NOT_AUTH = 3'd6;
  localparam logic [2:0] ST_BAD_OP   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic              found_q, found_d;
  logic [IDX_W-1:0]  found_idx_q, found_idx_d;
  logic [2:0]        op_q, op_d;
  logic [ACC_W-1:0]  lacc_q, lacc_d, ldest_q, ldest_d;
  logic [PIN_W-1:0]  lpin_q, lpin_d;
  logic [AMT_W-1:0]  lamt_q, lamt_d;
  logic              sess_q, sess_d;
  logic [IDX_W-1:0]  sidx_q, sidx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              tpulse_q, tpulse_d;
  logic [2:0]        status_q, status_d;
  logic [BAL_W-1:0]  rbal_q, rbal_d;

  logic [ACC_W-1:0]  acc_q   [NUM_ACCTS];
  logic [ACC_W-1:0]  acc_d   [NUM_ACCTS];
  logic [PIN_W-1:0]  pin_q   [NUM_ACCTS];
  logic [PIN_W-1:0]  pin_d   [NUM_ACCTS];
  logic              valid_q [NUM_ACCTS];
  logic              valid_d [NUM_ACCTS];
  logic              lock_q  [NUM_ACCTS];
  logic              lock_d  [NUM_ACCTS];
  logic [FAIL_W-1:0] fail_q  [NUM_ACCTS];
  logic [FAIL_W-1:0] fail_d  [NUM_ACCTS];
  logic [BAL_W-1:0]  bal_q   [NUM_ACCTS];
  logic [BAL_W-1:0]  bal_d   [NUM_ACCTS];

  logic              accept, expire, cfg_ok;
  logic [ACC_W-1:0]  scan_key;
  logic [BAL_W-1:0]  amt_ext, src_bal, dst_bal;
  logic [BAL_W:0]    dep_sum, xfer_sum;
  logic [FAIL_W-1:0] fail_inc;

  assign accept   = req_valid && (state_q == S_IDLE);
  // Expiry wins over a same-cycle accept, so that request runs without a session.
  assign expire   = sess_q && (state_q == S_IDLE) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign cfg_ok   = cfg_we && !sess_q && (state_q == S_IDLE) && ({1'b0, cfg_idx} < 5'(NUM_ACCTS));
  assign scan_key = (op_q == OP_LOGIN) ? lacc_q : ldest_q;
  assign amt_ext  = BAL_W'(lamt_q);
  assign src_bal  = bal_q[sidx_q];
  assign dst_bal  = bal_q[found_idx_q];
  assign dep_sum  = {1'b0, src_bal} + {1'b0, amt_ext};
  assign xfer_sum = {1'b0, dst_bal} + {1'b0, amt_ext};
  assign fail_inc = fail_q[found_idx_q] + FAIL_W'(1);

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    found_d     = found_q;
    found_idx_d = found_idx_q;
    op_d        = op_q;
    lacc_d      = lacc_q;
    ldest_d     = ldest_q;
    lpin_d      = lpin_q;
    lamt_d      = lamt_q;
    sess_d      = sess_q;
    sidx_d      = sidx_q;
    tmr_d       = tmr_q;
    tpulse_d    = 1'b0;
    status_d    = status_q;
    rbal_d      = rbal_q;
    acc_d       = acc_q;
    pin_d       = pin_q;
    valid_d     = valid_q;
    lock_d      = lock_q;
    fail_d      = fail_q;
    bal_d       = bal_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_ok) begin
          acc_d[cfg_idx]   = cfg_acc;
          pin_d[cfg_idx]   = cfg_pin;
          valid_d[cfg_idx] = 1'b1;
          lock_d[cfg_idx]  = 1'b0;
          fail_d[cfg_idx]  = '0;
        end
        if (expire) begin
          sess_d   = 1'b0;
          tmr_d    = '0;
          tpulse_d = 1'b1;
        end else if (accept) begin
          tmr_d = '0;
        end else if (sess_q) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (accept) begin
          op_d       = req_op;
          lacc_d     = req_acc;
          ldest_d    = req_dest;
          lpin_d     = req_pin;
          lamt_d     = req_amt;
          found_d    = 1'b0;
          scan_idx_d = '0;
          state_d    = (req_op == OP_LOGIN || req_op == OP_XFER) ? S_SCAN : S_EXEC;
        end
      end
      S_SCAN: begin
        if (!found_q && valid_q[scan_idx_q] && (acc_q[scan_idx_q] == scan_key)) begin
          found_d     = 1'b1;
          found_idx_d = scan_idx_q;
        end
        if (scan_idx_q == IDX_W'(NUM_ACCTS - 1)) state_d = S_EXEC;
        else scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      S_EXEC: begin
        state_d  = S_RESP;
        status_d = ST_OK;
        if (op_q > OP_XFER) begin
          status_d = ST_BAD_OP;
        end else if (op_q == OP_LOGIN) begin
          if (sess_q) status_d = ST_BAD_OP;
          else if (!found_q) status_d = ST_BAD_CRED;
          else if (lock_q[found_idx_q]) status_d = ST_LOCKED;
          else if (pin_q[found_idx_q] != lpin_q) begin
            fail_d[found_idx_q] = fail_inc;
            if (fail_inc >= FAIL_W'(MAX_TRIES)) begin
              lock_d[found_idx_q] = 1'b1;
              status_d            = ST_LOCKED;
            end else begin
              status_d = ST_BAD_CRED;
            end
          end else begin
            fail_d[found_idx_q] = '0;
            sess_d              = 1'b1;
            sidx_d              = found_idx_q;
          end
        end else if (!sess_q) begin
          status_d = ST_NOT_AUTH;
        end else begin
          case (op_q)
            OP_LOGOUT:  sess_d = 1'b0;
            OP_BALANCE: ;
            OP_WITHDRAW: begin
              if (amt_ext <= src_bal) bal_d[sidx_q] = src_bal - amt_ext;
              else status_d = ST_NSF;
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W]) status_d = ST_OVERFLOW;
              else bal_d[sidx_q] = dep_sum[BAL_W-1:0];
            end
            OP_XFER: begin
              if (!found_q || (found_idx_q == sidx_q)) status_d = ST_NO_DEST;
              else if (amt_ext > src_bal) status_d = ST_NSF;
              else if (xfer_sum[BAL_W]) status_d = ST_OVERFLOW;
              else begin
                bal_d[sidx_q]      = src_bal - amt_ext;
                bal_d[found_idx_q] = xfer_sum[BAL_W-1:0];
              end
            end
            default: ;
          endcase
        end
        rbal_d = sess_d ? bal_d[sidx_d] : '0;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scan_idx_q  <= '0;
      found_q     <= 1'b0;
      found_idx_q <= '0;
      op_q        <= '0;
      lacc_q      <= '0;
      ldest_q     <= '0;
      lpin_q      <= '0;
      lamt_q      <= '0;
      sess_q      <= 1'b0;
      sidx_q      <= '0;
      tmr_q       <= '0;
      tpulse_q    <= 1'b0;
      status_q    <= '0;
      rbal_q      <= '0;
      for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
        acc_q[i]   <= '0;
        pin_q[i]   <= '0;
        valid_q[i] <= 1'b0;
        lock_q[i]  <= 1'b0;
        fail_q[i]  <= '0;
        bal_q[i]   <= BAL_W'(INIT_BAL);
      end
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      found_q     <= found_d;
      found_idx_q <= found_idx_d;
      op_q        <= op_d;
      lacc_q      <= lacc_d;
      ldest_q     <= ldest_d;
      lpin_q      <= lpin_d;
      lamt_q      <= lamt_d;
      sess_q      <= sess_d;
      sidx_q      <= sidx_d;
      tmr_q       <= tmr_d;
      tpulse_q    <= tpulse_d;
      status_q    <= status_d;
      rbal_q      <= rbal_d;
      acc_q       <= acc_d;
      pin_q       <= pin_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      fail_q      <= fail_d;
      bal_q       <= bal_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_status     = status_q;
  assign rsp_balance    = rbal_q;
  assign session_active = sess_q;
  assign timeout_pulse  = tpulse_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed and randomized bench for atm_session_ctrl against a behavioural account model.
module tb_atm_session_ctrl;
  localparam int NUM       = 10;
  localparam int ACC_W     = 12;
  localparam int PIN_W     = 4;
  localparam int BAL_W     = 16;
  localparam int AMT_W     = 16;
  localparam int MAX_TRIES = 3;
  localparam int TMO       = 100;
  localparam int INIT_BAL  = 500;
  localparam int BAL_MAX   = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_idx = '0;
  logic [ACC_W-1:0] cfg_acc = '0;
  logic [PIN_W-1:0] cfg_pin = '0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [ACC_W-1:0] req_acc = '0;
  logic [PIN_W-1:0] req_pin = '0;
  logic [ACC_W-1:0] req_dest = '0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [2:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;
  logic             session_active;
  logic             timeout_pulse;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .NUM_ACCTS(NUM), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .AMT_W(AMT_W),
    .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TMO), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acc(cfg_acc),
    .cfg_pin(cfg_pin), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acc(req_acc), .req_pin(req_pin), .req_dest(req_dest), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .session_active(session_active), .timeout_pulse(timeout_pulse)
  );

  int checks = 0;
  int errors = 0;

  int m_acc [NUM];
  int m_pin [NUM];
  int m_fail[NUM];
  int m_bal [NUM];
  bit m_valid[NUM];
  bit m_lock [NUM];
  bit m_sess;
  int m_sidx;
  int pool[8] = '{4023, 4000, 3993, 1000, 1001, 1002, 1003, 9999};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_acc[i] = 0; m_pin[i] = 0; m_fail[i] = 0; m_bal[i] = INIT_BAL;
      m_valid[i] = 1'b0; m_lock[i] = 1'b0;
    end
    m_sess = 1'b0;
    m_sidx = 0;
  endtask

  function automatic int find_acct(input int acc);
    for (int i = 0; i < NUM; i++)
      if (m_valid[i] && m_acc[i] == acc) return i;
    return -1;
  endfunction

  task automatic model_exec(input int op, input int acc, input int pin, input int dest,
                            input int amt, output int st, output int bal);
    int s, d;
    st = 0;
    if (op >= 6) st = 7;
    else if (op == 0) begin
      s = find_acct(acc);
      if (m_sess) st = 7;
      else if (s < 0) st = 1;
      else if (m_lock[s]) st = 2;
      else if (m_pin[s] != pin) begin
        m_fail[s] = m_fail[s] + 1;
        if (m_fail[s] >= MAX_TRIES) begin m_lock[s] = 1'b1; st = 2; end
        else st = 1;
      end else begin
        m_fail[s] = 0; m_sess = 1'b1; m_sidx = s;
      end
    end else if (!m_sess) st = 6;
    else if (op == 1) m_sess = 1'b0;
    else if (op == 3) begin
      if (amt <= m_bal[m_sidx]) m_bal[m_sidx] -= amt; else st = 3;
    end else if (op == 4) begin
      if (m_bal[m_sidx] + amt > BAL_MAX) st = 4; else m_bal[m_sidx] += amt;
    end else if (op == 5) begin
      d = find_acct(dest);
      if (d < 0 || d == m_sidx) st = 5;
      else if (amt > m_bal[m_sidx]) st = 3;
      else if (m_bal[d] + amt > BAL_MAX) st = 4;
      else begin m_bal[m_sidx] -= amt; m_bal[d] += amt; end
    end
    bal = m_sess ? m_bal[m_sidx] : 0;
  endtask

  task automatic cfg(input int idx, input int acc, input int pin);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_acc = ACC_W'(acc); cfg_pin = PIN_W'(pin);
    @(posedge clk);
    if (idx < NUM && !m_sess) begin
      m_acc[idx] = acc; m_pin[idx] = pin; m_valid[idx] = 1'b1;
      m_lock[idx] = 1'b0; m_fail[idx] = 0;
    end
    #1 cfg_we = 1'b0;
  endtask

  task automatic do_req(input string tag, input int op, input int acc, input int pin,
                        input int dest, input int amt, output int st, output int bal);
    int est, ebal, elat, lat;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_op = 3'(op); req_acc = ACC_W'(acc); req_pin = PIN_W'(pin);
    req_dest = ACC_W'(dest); req_amt = AMT_W'(amt);
    @(posedge clk);
    elat = (op == 0 || op == 5) ? NUM + 2 : 2;
    model_exec(op, acc, pin, dest, amt, est, ebal);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 64);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_st"}, 32'(rsp_status), est);
    chk({tag, "_bal"}, 32'(rsp_balance), ebal);
    chk({tag, "_sess"}, 32'(session_active), 32'(m_sess));
    st = int'(rsp_status);
    bal = int'(rsp_balance);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_status"}, 32'(rsp_status), 0);
    chk({tag, "_rsp_balance"}, 32'(rsp_balance), 0);
    chk({tag, "_session"}, 32'(session_active), 0);
    chk({tag, "_tpulse"}, 32'(timeout_pulse), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, bal, est, ebal, lat, first, pulses;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    // 1: basic login with 12-cycle latency
    cfg(0, 4023, 0);
    cfg(1, 4000, 7);
    cfg(2, 3993, 5);
    cfg(6, 4023, 9);
    cfg(12, 1234, 1);
    do_req("t1_login", 0, 4023, 0, 0, 0, st, bal);
    chk("t1_st_lit", st, 0);
    chk("t1_bal_lit", bal, 500);
    do_req("t1_relogin", 0, 4023, 0, 0, 0, st, bal);
    chk("t1_relogin_lit", st, 7);
    do_req("t1_illegal", 6, 0, 0, 0, 0, st, bal);
    do_req("t1_logout", 1, 0, 0, 0, 0, st, bal);
    chk("t1_logout_bal", bal, 0);

    // 2: lockout and unlock via rewrite
    do_req("t2_bad1", 0, 4000, 1, 0, 0, st, bal);
    chk("t2_bad1_lit", st, 1);
    do_req("t2_bad2", 0, 4000, 1, 0, 0, st, bal);
    do_req("t2_bad3", 0, 4000, 1, 0, 0, st, bal);
    chk("t2_bad3_lit", st, 2);
    do_req("t2_good_locked", 0, 4000, 7, 0, 0, st, bal);
    chk("t2_locked_lit", st, 2);
    cfg(1, 4000, 7);
    do_req("t2_unlocked", 0, 4000, 7, 0, 0, st, bal);
    chk("t2_unlocked_lit", st, 0);
    do_req("t2_logout", 1, 0, 0, 0, 0, st, bal);
    do_req("t2_dup_lowest", 0, 4023, 9, 0, 0, st, bal);
    chk("t2_dup_lit", st, 1);
    do_req("t2_unknown", 0, 1111, 0, 0, 0, st, bal);
    do_req("t2_noauth", 2, 0, 0, 0, 0, st, bal);
    chk("t2_noauth_lit", st, 6);

    // 3: withdraw / deposit limits
    do_req("t3_login", 0, 4023, 0, 0, 0, st, bal);
    do_req("t3_wd501", 3, 0, 0, 0, 501, st, bal);
    chk("t3_wd501_lit", st, 3);
    do_req("t3_wd200", 3, 0, 0, 0, 200, st, bal);
    chk("t3_wd200_lit", bal, 300);
    do_req("t3_dep_ovf", 4, 0, 0, 0, 65300, st, bal);
    chk("t3_ovf_lit", st, 4);
    do_req("t3_dep_max", 4, 0, 0, 0, 65235, st, bal);
    chk("t3_max_lit", bal, 65535);
    do_req("t3_wd_back", 3, 0, 0, 0, 65235, st, bal);
    do_req("t3_restore", 4, 0, 0, 0, 200, st, bal);

    // 4: transfers
    do_req("t4_xfer", 5, 0, 0, 3993, 100, st, bal);
    chk("t4_src_lit", bal, 400);
    do_req("t4_nodest", 5, 0, 0, 9999, 10, st, bal);
    chk("t4_nodest_lit", st, 5);
    do_req("t4_self", 5, 0, 0, 4023, 10, st, bal);
    do_req("t4_nsf", 5, 0, 0, 3993, 401, st, bal);
    do_req("t4_zero", 5, 0, 0, 3993, 0, st, bal);
    do_req("t4_logout", 1, 0, 0, 0, 0, st, bal);
    do_req("t4_dest_login", 0, 3993, 5, 0, 0, st, bal);
    chk("t4_dest_lit", bal, 600);
    do_req("t4_fill", 4, 0, 0, 0, 64935, st, bal);
    do_req("t4_logout2", 1, 0, 0, 0, 0, st, bal);
    do_req("t4_login2", 0, 4023, 0, 0, 0, st, bal);
    do_req("t4_xfer_ovf", 5, 0, 0, 3993, 1, st, bal);
    chk("t4_ovf_lit", st, 4);
    do_req("t4_logout3", 1, 0, 0, 0, 0, st, bal);

    // 5: idle timeout
    do_req("t5_login", 0, 4023, 0, 0, 0, st, bal);
    first = -1;
    pulses = 0;
    for (int i = 1; i <= TMO + 10; i++) begin
      @(posedge clk);
      #1;
      if (timeout_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    m_sess = 1'b0;
    chk("t5_pulse_cycle", first, TMO);
    chk("t5_pulse_count", pulses, 1);
    chk("t5_session", 32'(session_active), 0);
    do_req("t5_bal", 2, 0, 0, 0, 0, st, bal);
    chk("t5_noauth_lit", st, 6);

    // 6: response back-pressure, then reset during SCAN
    do_req("t6_login", 0, 4000, 7, 0, 0, st, bal);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2;
    @(posedge clk);
    model_exec(2, 0, 0, 0, 0, est, ebal);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 64);
    chk("t6_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 32'(rsp_valid), 1);
      chk("t6_hold_st", 32'(rsp_status), est);
      chk("t6_hold_bal", 32'(rsp_balance), ebal);
      chk("t6_hold_rdy", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_acc = ACC_W'(4023); req_pin = '0;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    chk("t6_scan_rdy", 32'(req_ready), 0);
    chk("t6_scan_valid", 32'(rsp_valid), 0);
    rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("t6_post_rdy", 32'(req_ready), 1);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) cfg(i, pool[$urandom_range(0, 6)], $urandom_range(0, 15));
    for (int n = 0; n < 200; n++) begin
      int r, op, acc, pin, dest, amt, f;
      r = $urandom_range(0, 99);
      if (!m_sess && r < 10) begin
        cfg($urandom_range(0, 15), pool[$urandom_range(0, 6)], $urandom_range(0, 15));
        continue;
      end
      if (!m_sess) op = (r < 75) ? 0 : $urandom_range(1, 5);
      else op = $urandom_range(0, 7);
      acc = pool[$urandom_range(0, 7)];
      f = find_acct(acc);
      pin = (f >= 0 && $urandom_range(0, 1) == 1) ? m_pin[f] : $urandom_range(0, 15);
      dest = pool[$urandom_range(0, 7)];
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 800);
      do_req("rnd", op, acc, pin, dest, amt, st, bal);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
